fifo_watermark_trigger: RTL and testbench

Multi-channel, parametrised FIFO watermark trigger. It replaces the single-channel `trigger_from_FIFO`. For each channel it watches a FIFO's read-data count together with that FIFO's write and read enables. It then raises hysteretic full/empty flags, one-cycle entry pulses and aggregate flags. It sits beside the acquisition FIFOs and feeds the readout/DMA control logic.

---
 rtl/fifo_watermark_trigger_if.sv | 52 +++++
 rtl/fifo_watermark_trigger.sv | 168 ++++++++++++++++
 tb/tb_fifo_watermark_trigger.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_watermark_trigger_if.sv
// Bundle between the acquisition FIFOs and the watermark trigger.
// IRQ members exist only when TRIGGER_IRQ_EN is defined.
interface fifo_watermark_trigger_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 21
);
    logic [NUM_CH-1:0]       fifo_wr_en_i;
    logic [NUM_CH-1:0]       fifo_rd_en_i;
    logic [NUM_CH*CNT_W-1:0] fifo_rd_data_count_i;
    logic [NUM_CH-1:0]       trigger_FIFO_full_o;
    logic [NUM_CH-1:0]       trigger_FIFO_empty_o;
    logic [NUM_CH-1:0]       full_pulse_o;
    logic [NUM_CH-1:0]       empty_pulse_o;
    logic                    any_full_o;
    logic                    any_empty_o;
    logic [NUM_CH-1:0]       count_err_o;
`ifdef TRIGGER_IRQ_EN
    logic [NUM_CH-1:0]       irq_mask_i;
    logic                    irq_clr_i;
    logic                    irq_o;

    modport master (
        output fifo_wr_en_i, fifo_rd_en_i, fifo_rd_data_count_i,
        output irq_mask_i, irq_clr_i,
        input  trigger_FIFO_full_o, trigger_FIFO_empty_o,
        input  full_pulse_o, empty_pulse_o,
        input  any_full_o, any_empty_o, count_err_o, irq_o
    );

    modport slave (
        input  fifo_wr_en_i, fifo_rd_en_i, fifo_rd_data_count_i,
        input  irq_mask_i, irq_clr_i,
        output trigger_FIFO_full_o, trigger_FIFO_empty_o,
        output full_pulse_o, empty_pulse_o,
        output any_full_o, any_empty_o, count_err_o, irq_o
    );
`else
    modport master (
        output fifo_wr_en_i, fifo_rd_en_i, fifo_rd_data_count_i,
        input  trigger_FIFO_full_o, trigger_FIFO_empty_o,
        input  full_pulse_o, empty_pulse_o,
        input  any_full_o, any_empty_o, count_err_o
    );

    modport slave (
        input  fifo_wr_en_i, fifo_rd_en_i, fifo_rd_data_count_i,
        output trigger_FIFO_full_o, trigger_FIFO_empty_o,
        output full_pulse_o, empty_pulse_o,
        output any_full_o, any_empty_o, count_err_o
    );
`endif
endinterface

// File: rtl/fifo_watermark_trigger.sv
// Multi-channel hysteretic FIFO watermark trigger (full/empty flags, pulses).
// Define TRIGGER_IRQ_EN to add the maskable sticky interrupt output.
module fifo_watermark_trigger #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 21,
    parameter int DEPTH    = 12800,
    parameter int HI_ON    = 12799,
    parameter int HI_OFF   = 11520,
    parameter int LO_ON    = 2560,
    parameter int LO_OFF   = 3840,
    parameter int HOLD_CYC = 1
) (
    input  logic clk,
    input  logic reset,
    fifo_watermark_trigger_if.slave bus
);
    typedef enum logic [1:0] {
        ST_NORMAL,
        ST_FULL,
        ST_EMPTY
    } state_t;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] HI_ON_C  = CNT_W'(HI_ON);
    localparam logic [CNT_W-1:0] HI_OFF_C = CNT_W'(HI_OFF);
    localparam logic [CNT_W-1:0] LO_ON_C  = CNT_W'(LO_ON);
    localparam logic [CNT_W-1:0] LO_OFF_C = CNT_W'(LO_OFF);
    localparam logic [7:0]       HOLD_LAST = 8'(HOLD_CYC - 1);

    if (!(LO_ON < LO_OFF && LO_OFF <= HI_OFF &&
          HI_OFF < HI_ON && HI_ON <= DEPTH)) begin : g_bad_thresh
        $error("fifo_watermark_trigger: illegal threshold order");
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("fifo_watermark_trigger: NUM_CH out of range");
    end
    if (HOLD_CYC < 1 || HOLD_CYC > 255) begin : g_bad_hold
        $error("fifo_watermark_trigger: HOLD_CYC out of range");
    end

    logic [CNT_W-1:0]  cnt [NUM_CH];
    logic [NUM_CH-1:0] wr_dir;
    logic [NUM_CH-1:0] rd_dir;
    logic [NUM_CH-1:0] full_qual;
    logic [NUM_CH-1:0] empty_qual;
    logic [NUM_CH-1:0] full_exit;
    logic [NUM_CH-1:0] empty_exit;
    logic [NUM_CH-1:0] over;

    // Both enables set counts as idle, same as neither.
    assign wr_dir = bus.fifo_wr_en_i & ~bus.fifo_rd_en_i;
    assign rd_dir = bus.fifo_rd_en_i & ~bus.fifo_wr_en_i;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign cnt[c] = bus.fifo_rd_data_count_i[c*CNT_W +: CNT_W];
        assign full_qual[c]  = wr_dir[c] && (cnt[c] >= HI_ON_C);
        assign empty_qual[c] = rd_dir[c] && (cnt[c] <= LO_ON_C);
        assign full_exit[c]  = rd_dir[c] && (cnt[c] <= HI_OFF_C);
        assign empty_exit[c] = wr_dir[c] && (cnt[c] >= LO_OFF_C);
        assign over[c]       = cnt[c] > DEPTH_C;
    end

    state_t            st_q   [NUM_CH];
    state_t            st_d   [NUM_CH];
    logic [7:0]        hold_q [NUM_CH];
    logic [7:0]        hold_d [NUM_CH];
    logic [NUM_CH-1:0] full_d;
    logic [NUM_CH-1:0] empty_d;
    logic [NUM_CH-1:0] fp_d;
    logic [NUM_CH-1:0] ep_d;
    logic [NUM_CH-1:0] full_q;
    logic [NUM_CH-1:0] empty_q;
    logic [NUM_CH-1:0] fp_q;
    logic [NUM_CH-1:0] ep_q;
    logic [NUM_CH-1:0] err_q;
    logic              any_full_q;
    logic              any_empty_q;

    always_comb begin
        full_d  = '0;
        empty_d = '0;
        fp_d    = '0;
        ep_d    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            st_d[c]   = st_q[c];
            hold_d[c] = '0;
            unique case (st_q[c])
                ST_NORMAL: begin
                    if (full_qual[c] || empty_qual[c]) begin
                        // Enter on the last qualifying cycle of the hold window.
                        if (hold_q[c] == HOLD_LAST) begin
                            st_d[c] = full_qual[c] ? ST_FULL : ST_EMPTY;
                            fp_d[c] = full_qual[c];
                            ep_d[c] = empty_qual[c];
                        end else begin
                            hold_d[c] = hold_q[c] + 8'd1;
                        end
                    end
                end
                ST_FULL: begin
                    if (full_exit[c]) st_d[c] = ST_NORMAL;
                end
                ST_EMPTY: begin
                    if (empty_exit[c]) st_d[c] = ST_NORMAL;
                end
                default: st_d[c] = ST_NORMAL;
            endcase
            full_d[c]  = (st_d[c] == ST_FULL);
            empty_d[c] = (st_d[c] == ST_EMPTY);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                st_q[c]   <= ST_NORMAL;
                hold_q[c] <= '0;
            end
            full_q      <= '0;
            empty_q     <= '0;
            fp_q        <= '0;
            ep_q        <= '0;
            err_q       <= '0;
            any_full_q  <= 1'b0;
            any_empty_q <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                st_q[c]   <= st_d[c];
                hold_q[c] <= hold_d[c];
            end
            full_q      <= full_d;
            empty_q     <= empty_d;
            fp_q        <= fp_d;
            ep_q        <= ep_d;
            err_q       <= err_q | over;
            any_full_q  <= |full_d;
            any_empty_q <= |empty_d;
        end
    end

    assign bus.trigger_FIFO_full_o  = full_q;
    assign bus.trigger_FIFO_empty_o = empty_q;
    assign bus.full_pulse_o         = fp_q;
    assign bus.empty_pulse_o        = ep_q;
    assign bus.any_full_o           = any_full_q;
    assign bus.any_empty_o          = any_empty_q;
    assign bus.count_err_o          = err_q;

`ifdef TRIGGER_IRQ_EN
    logic irq_q;
    logic irq_set;

    assign irq_set = |((fp_d | ep_d) & ~bus.irq_mask_i);

    // A new event wins over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_q <= 1'b0;
        end else if (irq_set) begin
            irq_q <= 1'b1;
        end else if (bus.irq_clr_i) begin
            irq_q <= 1'b0;
        end
    end

    assign bus.irq_o = irq_q;
`endif
endmodule

// File: tb/tb_fifo_watermark_trigger.sv
// Directed bench for fifo_watermark_trigger, two instances (hold 1 and 3)
// sharing stimulus and checked against a reference model via a queue.
module tb_fifo_watermark_trigger;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 21;
    localparam int DEPTH  = 12800;
    localparam int HI_ON  = 12799;
    localparam int HI_OFF = 11520;
    localparam int LO_ON  = 2560;
    localparam int LO_OFF = 3840;

    typedef struct packed {
        logic [NUM_CH-1:0] full;
        logic [NUM_CH-1:0] empty;
        logic [NUM_CH-1:0] fp;
        logic [NUM_CH-1:0] ep;
        logic [NUM_CH-1:0] err;
        logic              af;
        logic              ae;
        logic              irq;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] wr;
    logic [NUM_CH-1:0] rd;
    int                cnt_v [NUM_CH];
    logic [NUM_CH*CNT_W-1:0] cnt_p;
    logic [NUM_CH-1:0] mask;
    logic              clr;

    int   n_assert = 0;
    int   n_fail   = 0;
    exp_t q [$];

    int   m_st   [2][NUM_CH];
    int   m_hold [2][NUM_CH];
    logic m_err  [2][NUM_CH];
    logic m_irq  [2];

    always #5 clk = ~clk;

    always_comb begin
        cnt_p = '0;
        for (int c = 0; c < NUM_CH; c++)
            cnt_p[c*CNT_W +: CNT_W] = CNT_W'(cnt_v[c]);
    end

    fifo_watermark_trigger_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) b1 ();
    fifo_watermark_trigger_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) b3 ();

    assign b1.fifo_wr_en_i = wr;
    assign b1.fifo_rd_en_i = rd;
    assign b1.fifo_rd_data_count_i = cnt_p;
    assign b3.fifo_wr_en_i = wr;
    assign b3.fifo_rd_en_i = rd;
    assign b3.fifo_rd_data_count_i = cnt_p;
`ifdef TRIGGER_IRQ_EN
    assign b1.irq_mask_i = mask;
    assign b1.irq_clr_i  = clr;
    assign b3.irq_mask_i = mask;
    assign b3.irq_clr_i  = clr;
`endif

    fifo_watermark_trigger #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .HOLD_CYC(1))
        dut (.clk(clk), .reset(rst_n), .bus(b1.slave));
    fifo_watermark_trigger #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .HOLD_CYC(3))
        dut3 (.clk(clk), .reset(rst_n), .bus(b3.slave));

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: 0 normal, 1 full, 2 empty.
    task automatic model(input int k, input int h, output exp_t e);
        logic w, r;
        e = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w = wr[c] && !rd[c];
            r = rd[c] && !wr[c];
            if (!rst_n) begin
                m_st[k][c] = 0;
                m_hold[k][c] = 0;
                m_err[k][c] = 1'b0;
            end else begin
                if (cnt_v[c] > DEPTH) m_err[k][c] = 1'b1;
                if (m_st[k][c] == 0) begin
                    if ((w && cnt_v[c] >= HI_ON) || (r && cnt_v[c] <= LO_ON)) begin
                        m_hold[k][c]++;
                        if (m_hold[k][c] >= h) begin
                            m_st[k][c] = w ? 1 : 2;
                            if (w) e.fp[c] = 1'b1;
                            else   e.ep[c] = 1'b1;
                            m_hold[k][c] = 0;
                        end
                    end else begin
                        m_hold[k][c] = 0;
                    end
                end else if (m_st[k][c] == 1) begin
                    m_hold[k][c] = 0;
                    if (r && cnt_v[c] <= HI_OFF) m_st[k][c] = 0;
                end else begin
                    m_hold[k][c] = 0;
                    if (w && cnt_v[c] >= LO_OFF) m_st[k][c] = 0;
                end
            end
            e.full[c]  = (m_st[k][c] == 1);
            e.empty[c] = (m_st[k][c] == 2);
            e.err[c]   = m_err[k][c];
        end
        e.af = |e.full;
        e.ae = |e.empty;
`ifdef TRIGGER_IRQ_EN
        if (!rst_n) m_irq[k] = 1'b0;
        else if (|((e.fp | e.ep) & ~mask)) m_irq[k] = 1'b1;
        else if (clr) m_irq[k] = 1'b0;
        e.irq = m_irq[k];
`endif
    endtask

    function automatic exp_t obs(input int k);
        exp_t o;
        o = '0;
        if (k == 0) begin
            o.full = b1.trigger_FIFO_full_o;
            o.empty = b1.trigger_FIFO_empty_o;
            o.fp = b1.full_pulse_o;
            o.ep = b1.empty_pulse_o;
            o.err = b1.count_err_o;
            o.af = b1.any_full_o;
            o.ae = b1.any_empty_o;
`ifdef TRIGGER_IRQ_EN
            o.irq = b1.irq_o;
`endif
        end else begin
            o.full = b3.trigger_FIFO_full_o;
            o.empty = b3.trigger_FIFO_empty_o;
            o.fp = b3.full_pulse_o;
            o.ep = b3.empty_pulse_o;
            o.err = b3.count_err_o;
            o.af = b3.any_full_o;
            o.ae = b3.any_empty_o;
`ifdef TRIGGER_IRQ_EN
            o.irq = b3.irq_o;
`endif
        end
        return o;
    endfunction

    task automatic tick();
        exp_t e, o;
        model(0, 1, e);
        q.push_back(e);
        model(1, 3, e);
        q.push_back(e);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            e = q.pop_front();
            o = obs(k);
            chk($sformatf("i%0d.full", k), 16'(o.full), 16'(e.full));
            chk($sformatf("i%0d.empty", k), 16'(o.empty), 16'(e.empty));
            chk($sformatf("i%0d.fpulse", k), 16'(o.fp), 16'(e.fp));
            chk($sformatf("i%0d.epulse", k), 16'(o.ep), 16'(e.ep));
            chk($sformatf("i%0d.err", k), 16'(o.err), 16'(e.err));
            chk($sformatf("i%0d.any_full", k), 16'(o.af), 16'(e.af));
            chk($sformatf("i%0d.any_empty", k), 16'(o.ae), 16'(e.ae));
`ifdef TRIGGER_IRQ_EN
            chk($sformatf("i%0d.irq", k), 16'(o.irq), 16'(e.irq));
`endif
        end
    endtask

    initial begin
        rst_n = 1'b0;
        wr = '0;
        rd = '0;
        mask = '0;
        clr = 1'b0;
        for (int c = 0; c < NUM_CH; c++) cnt_v[c] = 5000;
        for (int k = 0; k < 2; k++) m_irq[k] = 1'b0;

        // 1: reset with ch0 writing just below HI_ON, then cross it
        wr[0] = 1'b1;
        cnt_v[0] = 12798;
        tick();
        chk("rst_full", 16'(b1.trigger_FIFO_full_o), 16'h0);
        chk("rst_err", 16'(b1.count_err_o), 16'h0);
        rst_n = 1'b1;
        tick();
        chk("tp1_no_full", 16'(b1.trigger_FIFO_full_o), 16'h0);
        cnt_v[0] = 12799;
        tick();
        chk("tp1_full", 16'(b1.trigger_FIFO_full_o[0]), 16'h1);
        chk("tp1_pulse", 16'(b1.full_pulse_o[0]), 16'h1);
        chk("tp1_any", 16'(b1.any_full_o), 16'h1);
        tick();
        chk("tp1_pulse_off", 16'(b1.full_pulse_o[0]), 16'h0);
        tick();
        chk("tp1_h3_full", 16'(b3.trigger_FIFO_full_o[0]), 16'h1);
        wr[0] = 1'b0;

        // 2: hysteresis on ch1
        wr[1] = 1'b1;
        cnt_v[1] = 12799;
        tick();
        wr[1] = 1'b0;
        rd[1] = 1'b1;
        cnt_v[1] = 11521;
        tick();
        chk("tp2_hold_full", 16'(b1.trigger_FIFO_full_o[1]), 16'h1);
        cnt_v[1] = 11520;
        tick();
        chk("tp2_release", 16'(b1.trigger_FIFO_full_o[1]), 16'h0);
        cnt_v[1] = 2561;
        tick();
        chk("tp2_no_empty", 16'(b1.trigger_FIFO_empty_o[1]), 16'h0);
        cnt_v[1] = 2560;
        tick();
        chk("tp2_empty", 16'(b1.trigger_FIFO_empty_o[1]), 16'h1);
        chk("tp2_any_empty", 16'(b1.any_empty_o), 16'h1);
        tick();
        tick();
        rd[1] = 1'b0;
        wr[1] = 1'b1;
        cnt_v[1] = 3839;
        tick();
        chk("tp2_empty_stays", 16'(b1.trigger_FIFO_empty_o[1]), 16'h1);
        cnt_v[1] = 3840;
        tick();
        chk("tp2_empty_rel", 16'(b1.trigger_FIFO_empty_o[1]), 16'h0);
        wr[1] = 1'b0;

        // 3: idle cycles and the hold window on ch2
        wr[2] = 1'b1;
        rd[2] = 1'b1;
        cnt_v[2] = 12799;
        repeat (3) tick();
        chk("tp3_idle", 16'(b1.trigger_FIFO_full_o[2]), 16'h0);
        rd[2] = 1'b0;
        repeat (2) tick();
        rd[2] = 1'b1;
        tick();
        rd[2] = 1'b0;
        repeat (2) tick();
        chk("tp3_h3_wait", 16'(b3.trigger_FIFO_full_o[2]), 16'h0);
        tick();
        chk("tp3_h3_full", 16'(b3.trigger_FIFO_full_o[2]), 16'h1);
        chk("tp3_h3_pulse", 16'(b3.full_pulse_o[2]), 16'h1);
        wr[2] = 1'b0;

        // 4: sticky count error on ch3, then reset mid-FULL
        cnt_v[3] = 12801;
        tick();
        chk("tp4_err", 16'(b1.count_err_o), 16'h8);
        cnt_v[3] = 5000;
        tick();
        chk("tp4_err_sticky", 16'(b1.count_err_o), 16'h8);
        chk("tp4_ch0_full", 16'(b1.trigger_FIFO_full_o), 16'h5);
        rst_n = 1'b0;
        tick();
        chk("tp4_rst_full", 16'(b1.trigger_FIFO_full_o), 16'h0);
        chk("tp4_rst_err", 16'(b1.count_err_o), 16'h0);
        chk("tp4_rst_any", 16'(b1.any_full_o), 16'h0);
        rst_n = 1'b1;
        for (int c = 0; c < NUM_CH; c++) cnt_v[c] = 5000;
        tick();

`ifdef TRIGGER_IRQ_EN
        // 5: masked, unmasked, set-beats-clear, clear alone
        mask = 4'b0010;
        rd[1] = 1'b1;
        cnt_v[1] = 2560;
        tick();
        chk("tp5_masked_empty", 16'(b1.empty_pulse_o[1]), 16'h1);
        chk("tp5_masked_irq", 16'(b1.irq_o), 16'h0);
        repeat (2) tick();
        rd[1] = 1'b0;
        mask = 4'b0000;
        rd[2] = 1'b1;
        cnt_v[2] = 2560;
        tick();
        chk("tp5_irq_set", 16'(b1.irq_o), 16'h1);
        repeat (2) tick();
        rd[2] = 1'b0;
        rd[3] = 1'b1;
        cnt_v[3] = 2560;
        clr = 1'b1;
        tick();
        chk("tp5_set_wins", 16'(b1.irq_o), 16'h1);
        clr = 1'b0;
        repeat (2) tick();
        rd[3] = 1'b0;
        clr = 1'b1;
        tick();
        chk("tp5_clear", 16'(b1.irq_o), 16'h0);
        clr = 1'b0;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
